kyber_bram_arbiter: RTL and testbench
=====================================

# kyber_bram_arbiter

Shares the single 128-bit Kyber-side BRAM port between three requesters: the operand loader (req 0, reads BRAM into the core input registers), the result unloader (req 1, writes core outputs back to BRAM), and the host debug path (req 2, single-beat peeks/pokes from the register interface). It sits between the Kyber wrapper sequencing logic and the BRAM port.

It provides:
- round-robin arbitration between the three requesters;
- locked bursts, so a full 50- or 96-beat pk/sk/c transfer runs uninterrupted;
- read-return routing back to the requester that issued each read.

## Interface
Parameters:
- RD_LAT, 1: BRAM read latency in cycles (1..3)
- MAX_BURST, 128: maximum beats per grant; a lock is force-released after this many beats

Ports:
- reg_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  3  per-requester beat request; bit i = requester i
- lock  in  3  hold grant after the current beat
- we  in  3  1 = write beat, 0 = read beat
- addr  in  24  requester i address = addr[8*i +: 8]
- wdata  in  384  requester i data = wdata[128*i +: 128]
- gnt  out  3  one-hot grant, registered
- owner  out  2  index of the current or last owner
- bram_en  out  1  BRAM enable, registered
- bram_we  out  16  byte enables: 16'hFFFF on write beats, 0 otherwise
- bram_addr  out  8  registered BRAM address
- bram_wdata  out  128  registered BRAM write data
- bram_rddata  in  128  BRAM read data
- rvalid  out  3  one-hot read-data-valid
- rdata  out  128  equals bram_rddata; qualified by rvalid

## Operation
- States are IDLE and OWNED.
- Beat definition: a beat is accepted in any cycle where gnt[i] && req[i].
- IDLE:
  - If any req bit is high, pick the winner by round-robin, searching from last_owner+1 mod 3.
  - Register owner <= winner, gnt <= onehot(winner), beat_cnt <= 0, go to OWNED.
  - If no req bit is high, gnt = 0.
- OWNED, beat accepted:
  - beat_cnt increments.
  - If lock[owner]=0 or beat_cnt==MAX_BURST-1: gnt <= 0, last_owner <= owner, go to IDLE.
  - Otherwise stay in OWNED with the grant held.
- OWNED, req[owner]=0: release (gnt <= 0, last_owner <= owner, go to IDLE); no beat is issued.
- Requests from non-owners are ignored while in OWNED and stay pending.
- BRAM drive on an accepted beat at cycle t, applied at t+1:
  - bram_en=1, bram_addr=addr[owner], bram_we=we[owner]?16'hFFFF:0, bram_wdata=wdata[owner] on writes.
  - In cycles with no beat: bram_en=0 and bram_we=0; bram_addr and bram_wdata hold their values.
- Read tracking:
  - Each read beat pushes {valid, owner} into an RD_LAT+1 deep shift pipeline.
  - rvalid[id] is asserted when the entry emerges.
  - Write beats push valid=0.
- Reset values:
  - gnt=0, owner=0, bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0, rvalid=0.
  - last_owner=2, so requester 0 wins the first tie.
  - state=IDLE, beat_cnt=0, read pipeline cleared.
- Reset mid-burst: everything clears immediately. In-flight reads are dropped and never produce rvalid.

## Timing
- Arbitration latency: req rises at cycle t while in IDLE, gnt rises at t+1, first beat at t+1.
- Burst throughput: one beat per cycle while req and lock stay high.
- Release gap: last beat at t, gnt low at t+1 (IDLE arbitrates), next gnt at t+2. There is a one-cycle bubble between owners.
- Read latency: read beat at t, bram_en at t+1, rvalid[owner] and valid rdata at t+1+RD_LAT (t+2 at default).
- Write latency: write beat at t, bram_en/bram_we/bram_wdata presented at t+1.
- Simultaneous events:
  - If req[owner] drops in the same cycle another requester rises, the owner releases and the new requester wins at the IDLE arbitration in the next cycle.
  - Force-release at MAX_BURST takes precedence over lock=1.

## Test plan
- Reset, then req=3'b111 with all lock=0: grants rotate 0,1,2,0 with a one-cycle gap between grants; last_owner=2 after reset, so requester 0 is granted first.
- Requester 0 locked read burst of 50 beats, addr 0..49, while req[2] is held high: gnt stays 3'b001 for 50 cycles; rvalid[0] pulses 50 times, each 2 cycles after its beat; gnt[2] rises 2 cycles after the last beat.
- Requester 1 write burst of 47 beats starting at addr 102 with data k: bram_we=16'hFFFF, bram_addr 102..148, bram_wdata matches each beat one cycle later; rvalid stays 0.
- MAX_BURST=4 with requester 0 locked for 10 beats and req[1] high: grant is forced off after 4 beats; requester 1 gets one beat; requester 0 then regains the grant.
- Assert rst 1 cycle after a read beat: rvalid never pulses; all outputs read 0 on the next edge.
- RD_LAT=3: rvalid arrives exactly 4 cycles after the beat and is routed to the correct requester when requesters 0 and 2 interleave single-beat reads.

Source files
------------

// File: rtl/kyber_bram_arbiter.sv
// kyber_bram_arbiter
//   Shares the single 128-bit Kyber-side BRAM port between three requesters:
//   req 0 = operand loader, req 1 = result unloader, req 2 = host debug path.
//   Round-robin arbitration, locked bursts (force-released after MAX_BURST
//   beats), and read-return routing back to the requester that issued the read.
//
// Ports
//   reg_clk, rst          clock, asynchronous active-high reset
//   req/lock/we [2:0]     per-requester beat request, burst hold, write flag
//   addr [23:0]           requester i address  = addr[8*i +: 8]
//   wdata [383:0]         requester i data     = wdata[128*i +: 128]
//   gnt [2:0]             registered one-hot grant
//   owner [1:0]           current or most recent owner
//   bram_en/we/addr/wdata registered BRAM drive (one cycle after the beat)
//   bram_rddata [127:0]   BRAM read data
//   rvalid [2:0]          one-hot read-data-valid, RD_LAT+1 cycles after a read beat
//   rdata [127:0]         bram_rddata, qualified by rvalid

module kyber_bram_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 128
) (
    input  logic         reg_clk,
    input  logic         rst,
    input  logic [2:0]   req,
    input  logic [2:0]   lock,
    input  logic [2:0]   we,
    input  logic [23:0]  addr,
    input  logic [383:0] wdata,
    output logic [2:0]   gnt,
    output logic [1:0]   owner,
    output logic         bram_en,
    output logic [15:0]  bram_we,
    output logic [7:0]   bram_addr,
    output logic [127:0] bram_wdata,
    input  logic [127:0] bram_rddata,
    output logic [2:0]   rvalid,
    output logic [127:0] rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [2:0]           gnt_q, gnt_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           last_owner_q, last_owner_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 bram_en_q, bram_en_d;
    logic [15:0]          bram_we_q, bram_we_d;
    logic [7:0]           bram_addr_q, bram_addr_d;
    logic [127:0]         bram_wdata_q, bram_wdata_d;
    // Read-return tracking: stage 0 is written by the beat, stage RD_LAT
    // lines up with the BRAM data.
    logic [RD_LAT:0]      rd_vld_q, rd_vld_d;
    logic [RD_LAT:0][1:0] rd_id_q, rd_id_d;

    logic [1:0]   winner;
    logic         beat;
    logic         own_req;
    logic         own_lock;
    logic         own_we;
    logic         release_own;
    logic [7:0]   own_addr;
    logic [127:0] own_wdata;

    assign own_req   = req[owner_q];
    assign own_lock  = lock[owner_q];
    assign own_we    = we[owner_q];
    assign own_addr  = addr[8*owner_q +: 8];
    assign own_wdata = wdata[128*owner_q +: 128];

    // gnt_q is zero outside OWNED, so this is only true for the owner.
    assign beat = |(gnt_q & req);

    // Dropping req, an unlocked beat, or the final allowed beat all release.
    // The beat-count limit wins over lock.
    assign release_own = (state_q == OWNED) &&
                         (!own_req || !own_lock || (beat_cnt_q == CNT_LAST));

    // Round-robin: search starts at the requester after the last owner.
    always_comb begin
        case (last_owner_q)
            2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // State register
    always_ff @(posedge reg_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= 2'd2;
            beat_cnt_q   <= '0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= '0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            rd_vld_q     <= '0;
            rd_id_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            rd_vld_q     <= rd_vld_d;
            rd_id_q      <= rd_id_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req)       state_d = OWNED;
            OWNED:   if (release_own) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping and BRAM drive
    always_comb begin
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = winner;
                    gnt_d      = 3'b001 << winner;
                    beat_cnt_d = '0;
                end
            end
            OWNED: begin
                if (beat) beat_cnt_d = beat_cnt_q + 1'b1;
                if (release_own) begin
                    gnt_d        = '0;
                    last_owner_d = owner_q;
                end
            end
            default: gnt_d = '0;
        endcase

        // Address and write data hold between beats; enables drop.
        bram_en_d    = beat;
        bram_we_d    = (beat && own_we) ? 16'hFFFF : 16'h0000;
        bram_addr_d  = beat ? own_addr : bram_addr_q;
        bram_wdata_d = (beat && own_we) ? own_wdata : bram_wdata_q;

        rd_vld_d = {rd_vld_q[RD_LAT-1:0], beat && !own_we};
        rd_id_d  = {rd_id_q[RD_LAT-1:0], owner_q};
    end

    assign gnt        = gnt_q;
    assign owner      = owner_q;
    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign rvalid     = rd_vld_q[RD_LAT] ? (3'b001 << rd_id_q[RD_LAT]) : 3'b000;
    assign rdata      = bram_rddata;

endmodule

// File: tb/tb_kyber_bram_arbiter.sv
// Bench for kyber_bram_arbiter. Three instances share one stimulus:
//   dut 0: defaults (RD_LAT=1, MAX_BURST=128)
//   dut 1: MAX_BURST=4
//   dut 2: RD_LAT=3
// A BRAM stand-in returns f(addr) after RD_LAT cycles so rdata can be tied
// back to the address of the originating read beat.

module tb_kyber_bram_arbiter;

    logic         reg_clk;
    logic         rst;
    logic [2:0]   req, lock, we;
    logic [23:0]  addr;
    logic [383:0] wdata;

    logic [2:0]   gnt_o [3];
    logic [1:0]   own_o [3];
    logic         en_o  [3];
    logic [15:0]  we_o  [3];
    logic [7:0]   ba_o  [3];
    logic [127:0] bw_o  [3];
    logic [2:0]   rv_o  [3];
    logic [127:0] rd_o  [3];
    logic [127:0] bpipe [3][3];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    function automatic logic [127:0] bram_f(logic [7:0] a);
        return {16{a ^ 8'h5A}} ^ {4{a, 24'hC31F77}};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        kyber_bram_arbiter #(
            .RD_LAT   (g == 2 ? 3 : 1),
            .MAX_BURST(g == 1 ? 4 : 128)
        ) u_dut (
            .reg_clk    (reg_clk),
            .rst        (rst),
            .req        (req),
            .lock       (lock),
            .we         (we),
            .addr       (addr),
            .wdata      (wdata),
            .gnt        (gnt_o[g]),
            .owner      (own_o[g]),
            .bram_en    (en_o[g]),
            .bram_we    (we_o[g]),
            .bram_addr  (ba_o[g]),
            .bram_wdata (bw_o[g]),
            .bram_rddata(bpipe[g][g == 2 ? 2 : 0]),
            .rvalid     (rv_o[g]),
            .rdata      (rd_o[g])
        );
    end

    always @(posedge reg_clk) begin
        for (int g = 0; g < 3; g++) begin
            bpipe[g][0] <= bram_f(ba_o[g]);
            bpipe[g][1] <= bpipe[g][0];
            bpipe[g][2] <= bpipe[g][1];
        end
    end

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    // ---------------- reference model ----------------
    int maxb [3] = '{128, 4, 128};
    int rdl  [3] = '{1, 1, 3};

    bit m_owned [3];
    int m_own [3], m_last [3], m_cnt [3];

    logic [2:0]   e_gnt [3];
    logic [1:0]   e_owner [3];
    logic         e_en [3];
    logic [15:0]  e_we [3];
    logic [7:0]   e_addr [3];
    logic [127:0] e_wdata [3];
    logic [2:0]   e_rv [3];
    logic [127:0] e_rdata [3];

    typedef struct {
        int         dut;
        int         due;
        int         id;
        logic [7:0] a;
    } rd_t;
    rd_t rq[$];

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owned[d] = 0; m_own[d] = 0; m_last[d] = 2; m_cnt[d] = 0;
            e_gnt[d] = '0; e_owner[d] = '0; e_en[d] = 1'b0; e_we[d] = '0;
            e_addr[d] = '0; e_wdata[d] = '0; e_rv[d] = '0; e_rdata[d] = '0;
        end
        rq.delete();
    endtask

    // Applies the inputs currently on the pins to model d at edge number e.
    task automatic model_step(int d, int e);
        int  o;
        bit  b;
        rd_t r;
        o = m_own[d];
        b = m_owned[d] && req[o];
        e_en[d] = b;
        e_we[d] = '0;
        if (b) begin
            e_addr[d] = addr[8*o +: 8];
            if (we[o]) begin
                e_we[d]    = 16'hFFFF;
                e_wdata[d] = wdata[128*o +: 128];
            end else begin
                r.dut = d; r.due = e + rdl[d]; r.id = o; r.a = addr[8*o +: 8];
                rq.push_back(r);
            end
            m_cnt[d]++;
            if (!lock[o] || m_cnt[d] == maxb[d]) begin
                m_owned[d] = 0; m_last[d] = o;
            end
        end else if (m_owned[d]) begin
            m_owned[d] = 0; m_last[d] = o;
        end else if (req != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                if (req[(m_last[d] + k) % 3]) begin
                    m_own[d] = (m_last[d] + k) % 3;
                    break;
                end
            end
            m_owned[d] = 1; m_cnt[d] = 0;
        end
        e_gnt[d]   = m_owned[d] ? 3'(1 << m_own[d]) : 3'b000;
        e_owner[d] = 2'(m_own[d]);
    endtask

    // One clock: step models, take the edge, settle expected read returns.
    task automatic tick();
        for (int d = 0; d < 3; d++) model_step(d, cyc + 1);
        @(posedge reg_clk);
        cyc++;
        @(negedge reg_clk);
        for (int d = 0; d < 3; d++) begin
            e_rv[d] = '0; e_rdata[d] = '0;
        end
        foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
                e_rv[rq[i].dut][rq[i].id] = 1'b1;
                e_rdata[rq[i].dut] = bram_f(rq[i].a);
            end
        end
        for (int i = rq.size() - 1; i >= 0; i--)
            if (rq[i].due <= cyc) rq.delete(i);
    endtask

    task automatic do_reset();
        @(negedge reg_clk);
        rst = 1'b1; req = '0; lock = '0; we = '0;
        model_reset();
        repeat (2) @(negedge reg_clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            nvec++;
            if ({gnt_o[d], own_o[d], en_o[d], we_o[d], ba_o[d], bw_o[d], rv_o[d]} !== '0) begin
                nerr++;
                $display("FAIL reset dut%0d: got gnt=%b owner=%0d en=%b we=%h addr=%h rvalid=%b, want all 0",
                         d, gnt_o[d], own_o[d], en_o[d], we_o[d], ba_o[d], rv_o[d]);
            end
        end
        tick();
        nvec++;
        if (gnt_o[0] !== 3'b000) begin
            nerr++; $display("FAIL idle_gnt: got %b want 000", gnt_o[0]);
        end
    endtask

    task automatic test_rotation();
        bit [2:0] seq [7];
        seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        do_reset();
        req = 3'b111; lock = '0; we = '0; addr = 24'($urandom);
        for (int i = 0; i < 7; i++) begin
            tick();
            nvec++;
            if (gnt_o[0] !== seq[i]) begin
                nerr++; $display("FAIL rotation[%0d]: got gnt %b want %b", i, gnt_o[0], seq[i]);
            end
            nvec++;
            if (rv_o[0] !== e_rv[0]) begin
                nerr++; $display("FAIL rotation_rvalid[%0d]: got %b want %b", i, rv_o[0], e_rv[0]);
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_burst_read();
        int rvc = 0;
        do_reset();
        req = 3'b101; lock = 3'b001; we = '0; addr = 24'($urandom) & 24'hFFFF00;
        tick();
        nvec++;
        if (gnt_o[0] !== 3'b001) begin
            nerr++; $display("FAIL burst_rd_grant: got %b want 001", gnt_o[0]);
        end
        for (int i = 0; i < 50; i++) begin
            addr[7:0] = 8'(i);
            lock[0]   = (i < 49);
            tick();
            rvc += int'(rv_o[0][0]);
            nvec++;
            if (gnt_o[0] !== ((i < 49) ? 3'b001 : 3'b000)) begin
                nerr++; $display("FAIL burst_rd_gnt[%0d]: got %b", i, gnt_o[0]);
            end
            nvec++;
            if (rv_o[0] !== e_rv[0] || (e_rv[0] != 0 && rd_o[0] !== e_rdata[0])) begin
                nerr++; $display("FAIL burst_rd_ret[%0d]: got rvalid %b rdata %h want %b %h",
                                 i, rv_o[0], rd_o[0], e_rv[0], e_rdata[0]);
            end
        end
        tick();
        rvc += int'(rv_o[0][0]);
        nvec++;
        if (gnt_o[0] !== 3'b100) begin
            nerr++; $display("FAIL burst_rd_next_owner: got %b want 100", gnt_o[0]);
        end
        req = '0;
        repeat (3) begin
            tick();
            rvc += int'(rv_o[0][0]);
        end
        nvec++;
        if (rvc != 50) begin
            nerr++; $display("FAIL burst_rd_count: got %0d rvalid[0] pulses want 50", rvc);
        end
    endtask

    task automatic test_burst_write();
        logic [127:0] dat = '0;
        do_reset();
        req = 3'b010; lock = 3'b010; we = 3'b010;
        tick();
        nvec++;
        if (gnt_o[0] !== 3'b010) begin
            nerr++; $display("FAIL burst_wr_grant: got %b want 010", gnt_o[0]);
        end
        for (int k = 0; k < 47; k++) begin
            addr[15:8]      = 8'(102 + k);
            dat             = {$urandom, $urandom, $urandom, 32'(k)};
            wdata[255:128]  = dat;
            lock[1]         = (k < 46);
            tick();
            nvec++;
            if (en_o[0] !== 1'b1 || we_o[0] !== 16'hFFFF || ba_o[0] !== 8'(102 + k) ||
                bw_o[0] !== dat || rv_o[0] !== 3'b000) begin
                nerr++;
                $display("FAIL burst_wr[%0d]: got en=%b we=%h addr=%0d wdata=%h rvalid=%b want 1 ffff %0d %h 000",
                         k, en_o[0], we_o[0], ba_o[0], bw_o[0], rv_o[0], 102 + k, dat);
            end
        end
        req = '0;
        tick();
        nvec++;
        if (en_o[0] !== 1'b0 || we_o[0] !== 16'h0 || ba_o[0] !== 8'd148 || bw_o[0] !== dat) begin
            nerr++;
            $display("FAIL burst_wr_hold: got en=%b we=%h addr=%0d wdata=%h want 0 0 148 %h",
                     en_o[0], we_o[0], ba_o[0], bw_o[0], dat);
        end
    endtask

    task automatic test_max_burst();
        bit [2:0] seq [8];
        seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
        do_reset();
        req = 3'b011; lock = 3'b001; we = '0; addr = 24'($urandom);
        for (int i = 0; i < 8; i++) begin
            tick();
            nvec++;
            if (gnt_o[1] !== seq[i]) begin
                nerr++; $display("FAIL max_burst[%0d]: got gnt %b want %b", i, gnt_o[1], seq[i]);
            end
        end
        req = '0; lock = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b001; lock = '0; we = '0; addr = 24'($urandom) | 24'h1;
        tick();
        tick();
        nvec++;
        if (en_o[0] !== 1'b1) begin
            nerr++; $display("FAIL mid_rst_beat: got bram_en %b want 1", en_o[0]);
        end
        rst = 1'b1; req = '0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d += 2) begin
            nvec++;
            if ({gnt_o[d], own_o[d], en_o[d], we_o[d], ba_o[d], bw_o[d], rv_o[d]} !== '0) begin
                nerr++; $display("FAIL mid_rst_clear dut%0d: got gnt=%b en=%b addr=%h want 0",
                                 d, gnt_o[d], en_o[d], ba_o[d]);
            end
        end
        @(posedge reg_clk);
        @(negedge reg_clk);
        nvec++;
        if ({gnt_o[0], own_o[0], en_o[0], we_o[0], ba_o[0], bw_o[0], rv_o[0]} !== '0) begin
            nerr++; $display("FAIL mid_rst_edge: got gnt=%b en=%b addr=%h rvalid=%b want 0",
                             gnt_o[0], en_o[0], ba_o[0], rv_o[0]);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (rv_o[0] !== 3'b000 || rv_o[2] !== 3'b000) begin
                nerr++; $display("FAIL mid_rst_drop[%0d]: got rvalid %b/%b want 000", i, rv_o[0], rv_o[2]);
            end
        end
    endtask

    task automatic test_rdlat3();
        bit [2:0] pick [3];
        pick = '{3'b001, 3'b100, 3'b101};
        do_reset();
        lock = '0; we = '0;
        for (int i = 0; i < 45; i++) begin
            req  = (i < 40) ? pick[$urandom_range(0, 2)] : 3'b000;
            addr = 24'($urandom);
            tick();
            nvec++;
            if (rv_o[2] !== e_rv[2] || (e_rv[2] != 0 && rd_o[2] !== e_rdata[2])) begin
                nerr++; $display("FAIL rdlat3[%0d]: got rvalid %b rdata %h want %b %h",
                                 i, rv_o[2], rd_o[2], e_rv[2], e_rdata[2]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) != 0) req = 3'($urandom);
            for (int b = 0; b < 3; b++) lock[b] = ($urandom_range(0, 4) != 0);
            we    = 3'($urandom);
            addr  = 24'($urandom);
            wdata = {12{$urandom}} ^ {$urandom, 352'h0};
            tick();
            for (int d = 0; d < 3; d++) begin
                nvec++;
                if (gnt_o[d] !== e_gnt[d] || own_o[d] !== e_owner[d]) begin
                    nerr++; $display("FAIL rand_gnt dut%0d cyc%0d: got %b/%0d want %b/%0d",
                                     d, cyc, gnt_o[d], own_o[d], e_gnt[d], e_owner[d]);
                end
                nvec++;
                if (en_o[d] !== e_en[d] || we_o[d] !== e_we[d] || ba_o[d] !== e_addr[d] ||
                    bw_o[d] !== e_wdata[d]) begin
                    nerr++; $display("FAIL rand_bram dut%0d cyc%0d: got en=%b we=%h addr=%h want %b %h %h",
                                     d, cyc, en_o[d], we_o[d], ba_o[d], e_en[d], e_we[d], e_addr[d]);
                end
                nvec++;
                if (rv_o[d] !== e_rv[d] || (e_rv[d] != 0 && rd_o[d] !== e_rdata[d])) begin
                    nerr++; $display("FAIL rand_rd dut%0d cyc%0d: got rvalid %b want %b",
                                     d, cyc, rv_o[d], e_rv[d]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_burst_read();
        test_burst_write();
        test_max_burst();
        test_reset_mid();
        test_rdlat3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
